// File: rtl/phase_pkg.sv
// rtl/phase_pkg.sv - shared phase constants and unwrap FSM state encoding
package phase_pkg;

  localparam int                 PHASE_W     = 16;
  localparam logic [PHASE_W-1:0] PHASE_PI    = 16'h8000;
  localparam logic [PHASE_W-1:0] JUMP_TH_DEF = 16'd8192;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/phase_block_avg.sv
// rtl/phase_block_avg.sv - block-mean decimator over 2^AVG_LOG2 unwrapped samples
module phase_block_avg #(
  parameter int ACC_W    = 32,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [ACC_W-1:0] sample,
  input  logic             sample_valid,
  output logic [ACC_W-1:0] avg_out,
  output logic             avg_valid
);

  localparam int SUM_W = ACC_W + AVG_LOG2;

  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [AVG_LOG2-1:0] cnt;

  assign sum_next = sum + {{AVG_LOG2{sample[ACC_W-1]}}, sample};

  // Dropping the low AVG_LOG2 bits of the signed sum is a flooring divide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cnt       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else if (clear) begin
      sum       <= '0;
      cnt       <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        cnt <= cnt + 1'b1;
        if (cnt == {AVG_LOG2{1'b1}}) begin
          avg_out   <= sum_next[SUM_W-1:AVG_LOG2];
          avg_valid <= 1'b1;
          sum       <= '0;
        end else begin
          sum <= sum_next;
        end
      end
    end
  end

endmodule

// File: rtl/phase_unwrap_accum.sv
// rtl/phase_unwrap_accum.sv - wrapped-phase differencing integrator with jump,
// saturation and block-average outputs
module phase_unwrap_accum
  import phase_pkg::*;
#(
  parameter int                 ACC_W    = 32,
  parameter logic [PHASE_W-1:0] JUMP_TH  = JUMP_TH_DEF,
  parameter int                 AVG_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               phase_in_valid,
  output logic [ACC_W-1:0]   unwrap_out,
  output logic               unwrap_out_valid,
  output logic [15:0]        fringe_count,
  output logic               jump_err,
  output logic               sat_flag,
  output logic [ACC_W-1:0]   avg_out,
  output logic               avg_valid
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t             state;
  logic [PHASE_W-1:0] prev;
  logic [PHASE_W-1:0] delta;
  logic               delta_neg;
  logic [PHASE_W:0]   delta_ext;
  logic [PHASE_W:0]   delta_mag;
  logic [ACC_W:0]     sum_wide;
  logic               ovf;

  // Modulo-2^16 subtraction is exactly the shortest-arc wrapped difference.
  assign delta     = phase_in - prev;
  assign delta_neg = |(delta & PHASE_PI);
  assign delta_ext = {delta_neg, delta};
  assign delta_mag = delta_neg ? ({(PHASE_W+1){1'b0}} - delta_ext) : delta_ext;
  assign sum_wide  = {unwrap_out[ACC_W-1], unwrap_out}
                   + {{(ACC_W+1-PHASE_W){delta_neg}}, delta};
  assign ovf       = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  if (ACC_W >= 32) begin : g_fc_trunc
    assign fringe_count = unwrap_out[31:16];
  end else begin : g_fc_sext
    assign fringe_count = {{(32-ACC_W){unwrap_out[ACC_W-1]}}, unwrap_out[ACC_W-1:16]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      prev             <= '0;
      unwrap_out       <= '0;
      unwrap_out_valid <= 1'b0;
      jump_err         <= 1'b0;
      sat_flag         <= 1'b0;
    end else if (clear) begin
      state            <= S_IDLE;
      prev             <= '0;
      unwrap_out       <= '0;
      unwrap_out_valid <= 1'b0;
      jump_err         <= 1'b0;
      sat_flag         <= 1'b0;
    end else begin
      unwrap_out_valid <= phase_in_valid;
      jump_err         <= 1'b0;
      if (phase_in_valid) begin
        prev <= phase_in;
        case (state)
          S_IDLE: begin
            unwrap_out <= {{(ACC_W-PHASE_W){phase_in[PHASE_W-1]}}, phase_in};
            state      <= S_RUN;
          end
          S_RUN: begin
            jump_err <= delta_mag > {1'b0, JUMP_TH};
            if (ovf) begin
              unwrap_out <= sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
              sat_flag   <= 1'b1;
            end else begin
              unwrap_out <= sum_wide[ACC_W-1:0];
            end
          end
        endcase
      end
    end
  end

  phase_block_avg #(
    .ACC_W    (ACC_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .sample       (unwrap_out),
    .sample_valid (unwrap_out_valid),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid)
  );

endmodule
